// File: rtl/dsp_mac_seq_if.sv
// Handshake and datapath-control bundle between a MAC datapath owner and its sequencer.
interface dsp_mac_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             ce_in;
  logic             ce_m;
  logic             ce_p;
  logic             acc_clr;
  logic             busy;
  logic             done;

  modport master (
    output start, len, in_valid,
    input  in_ready, ce_in, ce_m, ce_p, acc_clr, busy, done
  );

  modport slave (
    input  start, len, in_valid,
    output in_ready, ce_in, ce_m, ce_p, acc_clr, busy, done
  );
endinterface

// File: rtl/dsp_mac_seq.sv
// Sequencer for a 3-stage (A/B -> M -> P) multiply-accumulate datapath: accepts N samples,
// steers the stage clock enables and clears the accumulator on the first product.
module dsp_mac_seq #(
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  dsp_mac_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [1:0]       vld_q, fst_q;
  logic             in_ready, ce_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      first_q <= 1'b0;
      vld_q   <= 2'b00;
      fst_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      vld_q   <= {vld_q[0], ce_in};
      fst_q   <= {fst_q[0], ce_in & first_q};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    in_ready = (state_q == StLoad);
    ce_in    = bus.in_valid & in_ready;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_d = StLoad;
            cnt_d   = bus.len;
            first_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        if (ce_in) begin
          cnt_d   = cnt_q - CNT_W'(1);
          first_d = 1'b0;
          if (cnt_q == CNT_W'(1)) state_d = StDrain;
        end
      end
      // Last product reaches P exactly when only the older token slot is occupied.
      StDrain: begin
        if (vld_q == 2'b10) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.ce_in    = ce_in;
  assign bus.ce_m     = vld_q[0];
  assign bus.ce_p     = vld_q[1];
  assign bus.acc_clr  = vld_q[1] & fst_q[1];
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: fixed cycle tables, directed corner sequences and a random run
// checked every cycle against an accept-history model of the sequencer.
module tb_dsp_mac_seq;

  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp_mac_seq_if #(.CNT_W(CNT_W)) bus ();

  dsp_mac_seq #(.CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r;
    logic       s;
    int         l;
    logic       v;
    logic [6:0] exp; // {in_ready, ce_in, ce_m, ce_p, acc_clr, busy, done}
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int n_done = 0;
  int n_clr  = 0;
  int n_cep  = 0;

  // Model state: samples still owed, run-active flag, cycle of the done pulse,
  // and the accept/first history of the last two cycles.
  int cyc        = 0;
  int m_rem      = 0;
  int m_done_cyc = -1;
  bit m_active   = 1'b0;
  bit m_first    = 1'b0;
  bit h_acc0 = 1'b0, h_acc1 = 1'b0, h_fst0 = 1'b0, h_fst1 = 1'b0;

  function automatic logic [6:0] model_exp(input bit v);
    bit rdy;
    rdy = (m_rem > 0);
    return {rdy, rdy & v, h_acc0, h_acc1, h_acc1 & h_fst1, m_active, cyc == m_done_cyc};
  endfunction

  task automatic model_edge(input bit r, input bit s, input int l, input bit v);
    bit acc, fst;
    if (r) begin
      m_rem = 0; m_active = 1'b0; m_done_cyc = -1; m_first = 1'b0;
      h_acc0 = 1'b0; h_acc1 = 1'b0; h_fst0 = 1'b0; h_fst1 = 1'b0;
    end else begin
      acc = (m_rem > 0) && v;
      fst = acc && m_first;
      h_acc1 = h_acc0; h_acc0 = acc;
      h_fst1 = h_fst0; h_fst0 = fst;
      if (acc) begin
        m_first = 1'b0;
        m_rem--;
        if (m_rem == 0) m_done_cyc = cyc + 3;
      end
      if (cyc == m_done_cyc) begin
        m_active = 1'b0;
      end else if (!m_active && s) begin
        m_active = 1'b1;
        if (l == 0) m_done_cyc = cyc + 1;
        else begin
          m_rem   = l;
          m_first = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  // One clock cycle: drive, sample mid-cycle, compare, advance model, cross the edge.
  task automatic step(input bit r, input bit s, input int l, input bit v,
                      input bit use_tab, input logic [6:0] tab_exp, input string nm);
    logic [6:0] act, exp;
    rst = r; bus.start = s; bus.len = CNT_W'(l); bus.in_valid = v;
    #3;
    act = {bus.in_ready, bus.ce_in, bus.ce_m, bus.ce_p, bus.acc_clr, bus.busy, bus.done};
    exp = use_tab ? tab_exp : model_exp(v);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: outputs {rdy,ce_in,ce_m,ce_p,clr,busy,done} got %b want %b",
               nm, cyc, act, exp);
    end
    if (act[0] === 1'b1) n_done++;
    if (act[2] === 1'b1) n_clr++;
    if (act[3] === 1'b1) n_cep++;
    model_edge(r, s, l, v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 7'b0, nm);
  endtask

  vec_t tab[$];

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Held in reset with start/in_valid active: everything stays low.
    step(1'b1, 1'b1, 3, 1'b1, 1'b1, 7'b0, "reset_hold");
    step(1'b1, 1'b1, 3, 1'b1, 1'b1, 7'b0, "reset_hold");

    // len=4 continuous, len=1, len=0.
    tab = '{
      '{1'b0, 1'b1, 4, 1'b1, 7'b0000000}, '{1'b0, 1'b0, 0, 1'b1, 7'b1100010},
      '{1'b0, 1'b0, 0, 1'b1, 7'b1110010}, '{1'b0, 1'b0, 0, 1'b1, 7'b1111110},
      '{1'b0, 1'b0, 0, 1'b1, 7'b1111010}, '{1'b0, 1'b0, 0, 1'b1, 7'b0011010},
      '{1'b0, 1'b0, 0, 1'b1, 7'b0001010}, '{1'b0, 1'b0, 0, 1'b1, 7'b0000011},
      '{1'b0, 1'b0, 0, 1'b1, 7'b0000000},
      '{1'b0, 1'b1, 1, 1'b1, 7'b0000000}, '{1'b0, 1'b0, 0, 1'b1, 7'b1100010},
      '{1'b0, 1'b0, 0, 1'b1, 7'b0010010}, '{1'b0, 1'b0, 0, 1'b1, 7'b0001110},
      '{1'b0, 1'b0, 0, 1'b1, 7'b0000011}, '{1'b0, 1'b0, 0, 1'b1, 7'b0000000},
      '{1'b0, 1'b1, 0, 1'b1, 7'b0000000}, '{1'b0, 1'b0, 0, 1'b1, 7'b0000011},
      '{1'b0, 1'b0, 0, 1'b1, 7'b0000000}
    };
    foreach (tab[i]) step(tab[i].r, tab[i].s, tab[i].l, tab[i].v, 1'b1, tab[i].exp, "table");

    // len=4 with an input gap on the second LOAD cycle.
    n_done = 0; n_clr = 0; n_cep = 0;
    step(1'b0, 1'b1, 4, 1'b0, 1'b0, 7'b0, "gap");
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 7'b0, "gap");
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 7'b0, "gap");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 7'b0, "gap");
    idle(6, "gap");
    check_cnt("gap_done_count", n_done, 1);
    check_cnt("gap_acc_clr_count", n_clr, 1);
    check_cnt("gap_ce_p_count", n_cep, 4);

    // start pulsed during LOAD and during DONE is ignored.
    n_done = 0;
    step(1'b0, 1'b1, 2, 1'b1, 1'b0, 7'b0, "start_ignore");
    step(1'b0, 1'b1, 6, 1'b1, 1'b0, 7'b0, "start_ignore");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 7'b0, "start_ignore");
    step(1'b0, 1'b1, 0, 1'b1, 1'b0, 7'b0, "start_ignore");
    idle(4, "start_ignore");
    check_cnt("start_ignore_done_count", n_done, 1);

    // Reset two cycles into a len=4 run, then a fresh run right as reset drops.
    n_done = 0;
    step(1'b0, 1'b1, 4, 1'b1, 1'b0, 7'b0, "mid_reset");
    step(1'b0, 1'b0, 0, 1'b1, 1'b0, 7'b0, "mid_reset");
    step(1'b1, 1'b0, 0, 1'b1, 1'b0, 7'b0, "mid_reset");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 7'b0, "mid_reset");
    check_cnt("mid_reset_no_done", n_done, 0);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0, 7'b0, "restart");
    step(1'b0, 1'b1, 3, 1'b1, 1'b0, 7'b0, "restart");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 7'b0, "restart");
    check_cnt("restart_done_count", n_done, 1);

    // Random traffic, including occasional resets and starts at arbitrary points.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0), 1'b0, 7'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
